// File: rtl/food_spawner.sv
// ---------------------------------------------------------------------------
// food_spawner
//
// Places food on the snake board and detects when the snake head lands on
// it. Food positions come from a free-running 16-bit Fibonacci LFSR. Each
// eat produces a single-cycle increment pulse for the score counter
// downstream, and then a new food position is chosen.
//
// Parameters:
//   COORD_W : coordinate width per axis. Legal range is 1..8.
//   SEED    : LFSR reset value. An all-zero seed would lock the LFSR, so it
//             is replaced by 16'hACE1.
//
// Ports:
//   clk        in   1        rising-edge clock for all state
//   reset      in   1        asynchronous, active-low reset
//   enable     in   1        game running; 0 freezes FSM, LFSR and head reg
//   head_x     in   COORD_W  snake head column
//   head_y     in   COORD_W  snake head row
//   head_valid in   1        one-cycle strobe: head moved to (head_x,head_y)
//   food_x     out  COORD_W  food column (registered)
//   food_y     out  COORD_W  food row (registered)
//   food_valid out  1        food currently placed and displayable
//   increment  out  1        one-cycle pulse per food eaten
//
// Build option:
//   FOOD_SPAWNER_AVOID_HEAD_EN
//     Defined   : a candidate equal to the last reported head position is
//                 rejected, so food never spawns under the head.
//     Undefined : every candidate is accepted; placement takes exactly one
//                 enabled cycle.
// ---------------------------------------------------------------------------
module food_spawner #(
    parameter int unsigned COORD_W = 4,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [COORD_W-1:0] head_x,
    input  logic [COORD_W-1:0] head_y,
    input  logic               head_valid,
    output logic [COORD_W-1:0] food_x,
    output logic [COORD_W-1:0] food_y,
    output logic               food_valid,
    output logic               increment
);

    // An all-zero LFSR never leaves zero, so substitute a known-good seed.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;

    typedef enum logic [0:0] {
        ST_PLACE = 1'b0,
        ST_ARMED = 1'b1
    } state_e;

    // One step of the 16-bit Fibonacci LFSR (taps 16,14,13,11).
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        logic fb;
        fb = cur[15] ^ cur[13] ^ cur[12] ^ cur[10];
        return {cur[14:0], fb};
    endfunction

    state_e             state_q;
    state_e             state_d;
    logic [15:0]        lfsr_q;
    logic [15:0]        lfsr_d;
    logic [COORD_W-1:0] food_x_q;
    logic [COORD_W-1:0] food_x_d;
    logic [COORD_W-1:0] food_y_q;
    logic [COORD_W-1:0] food_y_d;
    logic               food_valid_q;
    logic               food_valid_d;
    logic               increment_q;
    logic               increment_d;

    logic [COORD_W-1:0] cand_x_s;
    logic [COORD_W-1:0] cand_y_s;
    logic               accept_s;
    logic               eat_s;

    // Candidate is carved from the current (pre-step) LFSR value.
    assign cand_x_s = lfsr_q[2*COORD_W-1 -: COORD_W];
    assign cand_y_s = lfsr_q[COORD_W-1:0];

    // Eat uses the live head inputs so the pulse is not delayed a cycle
    // behind the movement strobe.
    assign eat_s = head_valid
                 & (head_x == food_x_q)
                 & (head_y == food_y_q);

`ifdef FOOD_SPAWNER_AVOID_HEAD_EN
    // The head register only matters when avoiding the head on placement.
    logic [COORD_W-1:0] hx_q;
    logic [COORD_W-1:0] hx_d;
    logic [COORD_W-1:0] hy_q;
    logic [COORD_W-1:0] hy_d;

    // Capture the last reported head position while the game runs.
    always_comb begin
        hx_d = hx_q;
        hy_d = hy_q;
        if (enable && head_valid) begin
            hx_d = head_x;
            hy_d = head_y;
        end else begin
            hx_d = hx_q;
            hy_d = hy_q;
        end
    end

    // Head position register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hx_q <= {COORD_W{1'b0}};
            hy_q <= {COORD_W{1'b0}};
        end else begin
            hx_q <= hx_d;
            hy_q <= hy_d;
        end
    end

    // Reject a candidate sitting under the last reported head; the LFSR
    // keeps stepping so the next cycle offers a fresh candidate.
    always_comb begin
        accept_s = 1'b1;
        if ((cand_x_s == hx_q) && (cand_y_s == hy_q)) begin
            accept_s = 1'b0;
        end else begin
            accept_s = 1'b1;
        end
    end
`else
    // Without head avoidance every candidate is taken immediately.
    assign accept_s = 1'b1;
`endif

    // FSM next state, LFSR stepping and output register updates.
    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        food_x_d     = food_x_q;
        food_y_d     = food_y_q;
        food_valid_d = food_valid_q;
        // The pulse defaults low so it can never last beyond one cycle and
        // is dropped at the next edge when the game is paused.
        increment_d  = 1'b0;

        if (enable) begin
            lfsr_d = lfsr_step(lfsr_q);
            case (state_q)
                ST_PLACE: begin
                    // head_valid here never scores; a snake cannot eat
                    // food that is not yet on the board.
                    if (accept_s) begin
                        food_x_d     = cand_x_s;
                        food_y_d     = cand_y_s;
                        food_valid_d = 1'b1;
                        state_d      = ST_ARMED;
                    end else begin
                        state_d      = ST_PLACE;
                    end
                end
                ST_ARMED: begin
                    if (eat_s) begin
                        increment_d  = 1'b1;
                        food_valid_d = 1'b0;
                        state_d      = ST_PLACE;
                    end else begin
                        state_d      = ST_ARMED;
                    end
                end
                default: begin
                    // Illegal encoding: drop the food and re-place it.
                    food_valid_d = 1'b0;
                    state_d      = ST_PLACE;
                end
            endcase
        end else begin
            state_d = state_q;
            lfsr_d  = lfsr_q;
        end
    end

    // State, LFSR and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_PLACE;
            lfsr_q       <= SEED_EFF;
            food_x_q     <= {COORD_W{1'b0}};
            food_y_q     <= {COORD_W{1'b0}};
            food_valid_q <= 1'b0;
            increment_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            food_x_q     <= food_x_d;
            food_y_q     <= food_y_d;
            food_valid_q <= food_valid_d;
            increment_q  <= increment_d;
        end
    end

    assign food_x     = food_x_q;
    assign food_y     = food_y_q;
    assign food_valid = food_valid_q;
    assign increment  = increment_q;

endmodule

// File: tb/tb_food_spawner.sv
// ---------------------------------------------------------------------------
// Self-checking bench for food_spawner.
// dut_a (SEED=16'h0001) exercises placement, eating, enable gating and
// asynchronous reset. dut_b (SEED=16'h0100) exercises head avoidance.
// Expected food placements are pushed to a queue by a bench model when it
// places food and popped when dut_a raises food_valid.
// ---------------------------------------------------------------------------
module tb_food_spawner;

    logic       clk;
    logic       rst_a;
    logic       en_a;
    logic [3:0] head_x_a;
    logic [3:0] head_y_a;
    logic       hv_a;
    logic [3:0] food_x_a;
    logic [3:0] food_y_a;
    logic       food_valid_a;
    logic       increment_a;

    logic       rst_b;
    logic       en_b;
    logic [3:0] head_x_b;
    logic [3:0] head_y_b;
    logic       hv_b;
    logic [3:0] food_x_b;
    logic [3:0] food_y_b;
    logic       food_valid_b;
    logic       increment_b;

    int errors;
    int checks;

    // Bench model of dut_a
    logic [15:0] m_lfsr;
    logic        m_armed;
    logic [3:0]  m_fx;
    logic [3:0]  m_fy;
    logic        m_fv;
    logic        m_inc;
    logic [3:0]  m_hx;
    logic [3:0]  m_hy;
    int          m_eats;
    int          inc_count;
    logic        prev_fv;
    logic        prev_inc;
    logic [7:0]  exp_q[$];

    food_spawner #(.COORD_W(4), .SEED(16'h0001)) dut_a (
        .clk(clk), .reset(rst_a), .enable(en_a),
        .head_x(head_x_a), .head_y(head_y_a), .head_valid(hv_a),
        .food_x(food_x_a), .food_y(food_y_a),
        .food_valid(food_valid_a), .increment(increment_a)
    );

    food_spawner #(.COORD_W(4), .SEED(16'h0100)) dut_b (
        .clk(clk), .reset(rst_b), .enable(en_b),
        .head_x(head_x_b), .head_y(head_y_b), .head_valid(hv_b),
        .food_x(food_x_b), .food_y(food_y_b),
        .food_valid(food_valid_b), .increment(increment_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    task automatic model_reset();
        m_lfsr   = 16'h0001;
        m_armed  = 1'b0;
        m_fx     = 4'd0;
        m_fy     = 4'd0;
        m_fv     = 1'b0;
        m_inc    = 1'b0;
        m_hx     = 4'd0;
        m_hy     = 4'd0;
        prev_fv  = 1'b0;
        prev_inc = 1'b0;
    endtask

    task automatic model_edge();
        logic [3:0] cx;
        logic [3:0] cy;
        logic       acc;
        m_inc = 1'b0;
        if (en_a) begin
            cx = m_lfsr[7:4];
            cy = m_lfsr[3:0];
            if (!m_armed) begin
                acc = 1'b1;
`ifdef FOOD_SPAWNER_AVOID_HEAD_EN
                if (cx == m_hx && cy == m_hy) acc = 1'b0;
`endif
                if (acc) begin
                    m_fx = cx; m_fy = cy; m_fv = 1'b1; m_armed = 1'b1;
                    exp_q.push_back({cx, cy});
                end
            end else if (hv_a && head_x_a == m_fx && head_y_a == m_fy) begin
                m_inc = 1'b1; m_fv = 1'b0; m_armed = 1'b0;
                m_eats++;
            end
            if (hv_a) begin
                m_hx = head_x_a;
                m_hy = head_y_a;
            end
            m_lfsr = lfsr_next(m_lfsr);
        end
    endtask

    // Advance one clock; the scoreboard pops on each food_valid rise.
    task automatic tick();
        logic [7:0] exp_pos;
        @(posedge clk);
        model_edge();
        #1;
        if (food_valid_a && !prev_fv) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_food: got placement %0h,%0h required none", food_x_a, food_y_a);
            end else begin
                exp_pos = exp_q.pop_front();
                if ({food_x_a, food_y_a} !== exp_pos) begin
                    errors++;
                    $display("FAIL sb_food: got %0h,%0h required %0h,%0h",
                             food_x_a, food_y_a, exp_pos[7:4], exp_pos[3:0]);
                end
            end
        end
        if (increment_a) begin
            inc_count++;
            checks++;
            if (prev_inc) begin
                errors++;
                $display("FAIL inc_consecutive: got 1 on two cycles required single pulse");
            end
        end
        prev_fv  = food_valid_a;
        prev_inc = increment_a;
    endtask

    task automatic test_reset();
        #12;
        checks += 4;
        if (food_x_a !== 4'd0) begin errors++; $display("FAIL rst_food_x: got %0h required 0", food_x_a); end
        if (food_y_a !== 4'd0) begin errors++; $display("FAIL rst_food_y: got %0h required 0", food_y_a); end
        if (food_valid_a !== 1'b0) begin errors++; $display("FAIL rst_food_valid: got %0b required 0", food_valid_a); end
        if (increment_a !== 1'b0) begin errors++; $display("FAIL rst_increment: got %0b required 0", increment_a); end
        @(posedge clk);
        #1;
        rst_a = 1'b1;
        tick();
        checks += 4;
        if (food_x_a !== 4'd0) begin errors++; $display("FAIL first_food_x: got %0h required 0", food_x_a); end
        if (food_y_a !== 4'd1) begin errors++; $display("FAIL first_food_y: got %0h required 1", food_y_a); end
        if (food_valid_a !== 1'b1) begin errors++; $display("FAIL first_food_valid: got %0b required 1", food_valid_a); end
        if (increment_a !== 1'b0) begin errors++; $display("FAIL first_increment: got %0b required 0", increment_a); end
    endtask

    task automatic test_no_false_eat();
        head_x_a = 4'd3; head_y_a = 4'd5; hv_a = 1'b1;
        tick();
        hv_a = 1'b0;
        checks += 3;
        if (increment_a !== 1'b0) begin errors++; $display("FAIL nofalse_inc: got %0b required 0", increment_a); end
        if ({food_x_a, food_y_a} !== 8'h01) begin errors++; $display("FAIL nofalse_food: got %0h,%0h required 0,1", food_x_a, food_y_a); end
        if (food_valid_a !== 1'b1) begin errors++; $display("FAIL nofalse_valid: got %0b required 1", food_valid_a); end
    endtask

    task automatic test_eat();
        int cnt0;
        cnt0 = inc_count;
        head_x_a = 4'd0; head_y_a = 4'd1; hv_a = 1'b1;
        tick();
        hv_a = 1'b0;
        checks += 2;
        if (increment_a !== 1'b1) begin errors++; $display("FAIL eat_inc: got %0b required 1", increment_a); end
        if (food_valid_a !== 1'b0) begin errors++; $display("FAIL eat_valid_fall: got %0b required 0", food_valid_a); end
        tick();
        checks += 4;
        if (increment_a !== 1'b0) begin errors++; $display("FAIL eat_inc_end: got %0b required 0", increment_a); end
        if (food_valid_a !== 1'b1) begin errors++; $display("FAIL eat_replace_valid: got %0b required 1", food_valid_a); end
        if ({food_x_a, food_y_a} !== 8'h08) begin errors++; $display("FAIL eat_replace_pos: got %0h,%0h required 0,8", food_x_a, food_y_a); end
        if (inc_count !== cnt0 + 1) begin errors++; $display("FAIL eat_counter: got %0d required %0d", inc_count, cnt0 + 1); end
    endtask

    task automatic test_enable_gating();
        en_a = 1'b0;
        head_x_a = m_fx; head_y_a = m_fy; hv_a = 1'b1;
        tick();
        tick();
        checks += 3;
        if (increment_a !== 1'b0) begin errors++; $display("FAIL gate_inc: got %0b required 0", increment_a); end
        if (food_valid_a !== 1'b1) begin errors++; $display("FAIL gate_valid: got %0b required 1", food_valid_a); end
        if ({food_x_a, food_y_a} !== 8'h08) begin errors++; $display("FAIL gate_food: got %0h,%0h required 0,8", food_x_a, food_y_a); end
        en_a = 1'b1;
        tick();
        hv_a = 1'b0;
        checks++;
        if (increment_a !== 1'b1) begin errors++; $display("FAIL gate_eat_inc: got %0b required 1", increment_a); end
        en_a = 1'b0;
        tick();
        checks += 2;
        if (increment_a !== 1'b0) begin errors++; $display("FAIL gate_pulse_clear: got %0b required 0", increment_a); end
        if (food_valid_a !== 1'b0) begin errors++; $display("FAIL gate_place_hold: got %0b required 0", food_valid_a); end
        en_a = 1'b1;
        tick();
        checks += 2;
        if (food_valid_a !== 1'b1) begin errors++; $display("FAIL gate_place_valid: got %0b required 1", food_valid_a); end
        if ({food_x_a, food_y_a} !== 8'h20) begin errors++; $display("FAIL gate_lfsr_hold: got %0h,%0h required 2,0", food_x_a, food_y_a); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) begin
            head_x_a = m_fx; head_y_a = m_fy; hv_a = 1'b1;
            tick();
            checks += 2;
            if (increment_a !== 1'b1) begin errors++; $display("FAIL b2b_inc[%0d]: got %0b required 1", i, increment_a); end
            if (food_valid_a !== 1'b0) begin errors++; $display("FAIL b2b_valid_fall[%0d]: got %0b required 0", i, food_valid_a); end
            // Head strobe repeated at the same spot while placing: no score.
            tick();
            hv_a = 1'b0;
            checks += 3;
            if (increment_a !== 1'b0) begin errors++; $display("FAIL b2b_no_repeat[%0d]: got %0b required 0", i, increment_a); end
            if (food_valid_a !== m_fv) begin errors++; $display("FAIL b2b_valid[%0d]: got %0b required %0b", i, food_valid_a, m_fv); end
            if ({food_x_a, food_y_a} !== {m_fx, m_fy}) begin errors++; $display("FAIL b2b_food[%0d]: got %0h,%0h required %0h,%0h", i, food_x_a, food_y_a, m_fx, m_fy); end
            for (int k = 0; k < 4 && !m_armed; k++) tick();
        end
    endtask

    task automatic test_async_reset();
        head_x_a = m_fx; head_y_a = m_fy; hv_a = 1'b1;
        tick();
        hv_a = 1'b0;
        checks++;
        if (increment_a !== 1'b1) begin errors++; $display("FAIL ar_pre_inc: got %0b required 1", increment_a); end
        #2;
        rst_a = 1'b0;
        #1;
        checks += 4;
        if (increment_a !== 1'b0) begin errors++; $display("FAIL ar_inc: got %0b required 0", increment_a); end
        if (food_valid_a !== 1'b0) begin errors++; $display("FAIL ar_valid: got %0b required 0", food_valid_a); end
        if (food_x_a !== 4'd0) begin errors++; $display("FAIL ar_food_x: got %0h required 0", food_x_a); end
        if (food_y_a !== 4'd0) begin errors++; $display("FAIL ar_food_y: got %0h required 0", food_y_a); end
        model_reset();
        @(posedge clk);
        #1;
        rst_a = 1'b1;
        tick();
        checks += 2;
        if ({food_x_a, food_y_a} !== 8'h01) begin errors++; $display("FAIL ar_replace: got %0h,%0h required 0,1", food_x_a, food_y_a); end
        if (food_valid_a !== 1'b1) begin errors++; $display("FAIL ar_replace_valid: got %0b required 1", food_valid_a); end
    endtask

    task automatic test_avoid_head();
        @(posedge clk);
        #1;
        rst_b = 1'b1;
`ifdef FOOD_SPAWNER_AVOID_HEAD_EN
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (food_valid_b !== 1'b0) begin errors++; $display("FAIL avoid_reject[%0d]: got %0b required 0", i, food_valid_b); end
        end
        @(posedge clk);
        #1;
        checks += 2;
        if ({food_x_b, food_y_b} !== 8'h01) begin errors++; $display("FAIL avoid_pos: got %0h,%0h required 0,1", food_x_b, food_y_b); end
        if (food_valid_b !== 1'b1) begin errors++; $display("FAIL avoid_valid: got %0b required 1", food_valid_b); end
`else
        @(posedge clk);
        #1;
        checks += 2;
        if ({food_x_b, food_y_b} !== 8'h00) begin errors++; $display("FAIL noavoid_pos: got %0h,%0h required 0,0", food_x_b, food_y_b); end
        if (food_valid_b !== 1'b1) begin errors++; $display("FAIL noavoid_valid: got %0b required 1", food_valid_b); end
`endif
    endtask

    initial begin
        errors = 0; checks = 0; m_eats = 0; inc_count = 0;
        rst_a = 1'b0; en_a = 1'b1; head_x_a = 4'd0; head_y_a = 4'd0; hv_a = 1'b0;
        rst_b = 1'b0; en_b = 1'b1; head_x_b = 4'd0; head_y_b = 4'd0; hv_b = 1'b0;
        model_reset();

        test_reset();
        test_no_false_eat();
        test_eat();
        test_enable_gating();
        test_back_to_back();
        test_async_reset();
        test_avoid_head();

        checks += 2;
        if (inc_count !== m_eats) begin errors++; $display("FAIL total_eats: got %0d required %0d", inc_count, m_eats); end
        if (exp_q.size() !== 0) begin errors++; $display("FAIL sb_leftover: got %0d pending required 0", exp_q.size()); end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/food_spawner.md
# food_spawner

Places food on the 16x16 snake board with a free-running LFSR and detects when the snake head lands on it. On each eat it emits a one-cycle `increment` pulse, which drives the `increment` input of the score counter directly downstream. It then re-places the food. The block sits between the snake movement logic (head position strobe) and the score/7-segment counter.

## Interface
Parameters:
- `COORD_W`, default 4: coordinate width per axis. Legal range is 1..8.
- `SEED`, default 16'hACE1: LFSR reset value. A value of 16'h0000 is replaced by 16'hACE1.

Ports:
- `clk`  in  1: single clock. All state is on its rising edge.
- `reset`  in  1: asynchronous, active-low. 0 clears all state immediately.
- `enable`  in  1: game running. When 0, the FSM, LFSR and head register all hold.
- `head_x`  in  COORD_W: snake head column.
- `head_y`  in  COORD_W: snake head row.
- `head_valid`  in  1: one-cycle strobe. Head has just moved to (`head_x`,`head_y`).
- `food_x`  out  COORD_W: food column. Registered.
- `food_y`  out  COORD_W: food row. Registered.
- `food_valid`  out  1: food currently placed and displayable.
- `increment`  out  1: one-cycle pulse per food eaten. Feeds the score counter.

## Operation
- **LFSR:** 16-bit Fibonacci, next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}. Steps on every clock with `enable`=1, in all states.
- **Candidate:** x = lfsr[2*COORD_W-1:COORD_W], y = lfsr[COORD_W-1:0], taken from the current (pre-step) value.
- **Head register** (`hx_q`,`hy_q`): loaded on `head_valid`&`enable`. Reset value is (0,0).
- **FSM states:** PLACE, ARMED. Reset state is PLACE.
  - PLACE: each enabled cycle, evaluate the candidate.
    - If accepted: latch `food_x`/`food_y` = candidate, set `food_valid`=1, go to ARMED.
    - If rejected: stay in PLACE. The LFSR advances, so the next cycle offers a new candidate.
    - `head_valid` in PLACE updates the head register only. It never produces `increment`.
  - ARMED: on `head_valid`&`enable` with (`head_x`,`head_y`)==(`food_x`,`food_y`):
    - `increment`=1 on the next cycle.
    - `food_valid`=0.
    - Go to PLACE.
  - ARMED, non-matching `head_valid`: update the head register only.
- **Eat comparison** uses live `head_x`/`head_y`, not `hx_q`/`hy_q`.
- **`increment` width:** exactly one cycle high per eat. It is never asserted on consecutive cycles.

## Timing
- **Reset values:** `food_x`=0, `food_y`=0, `food_valid`=0, `increment`=0, lfsr=SEED, state=PLACE.
- **Eat latency:** match sampled at edge N gives:
  - `increment`=1 and `food_valid`=0 during cycle N..N+1.
  - `increment`=0 after edge N+1.
- **Placement:** the earliest new `food_valid` rise is at edge N+1, if the candidate evaluated at N+1 is accepted. Each rejection adds one cycle.
- **`enable`=0:**
  - FSM, LFSR and head register hold.
  - `increment` is forced to 0 on the next edge.
  - A pending pulse already high still clears at the next edge.
- **Reset mid-operation:** all outputs go to their reset values asynchronously, including mid-pulse `increment`.
- **`head_valid` on the same edge PLACE accepts:** the placement completes. The head register updates. No eat is checked until ARMED.

## Configuration
- Macro: `FOOD_SPAWNER_AVOID_HEAD_EN`.
- **Defined:** in PLACE, a candidate equal to (`hx_q`,`hy_q`) is rejected. Food never spawns under the last reported head.
- **Undefined:** every candidate is accepted. PLACE always lasts exactly one enabled cycle.

## Test plan
- **Reset and first placement:** SEED=16'h0001, COORD_W=4, hold `reset`=0 then release, `enable`=1.
  - After the first edge: `food_x`=0, `food_y`=1, `food_valid`=1, `increment`=0.
- **Eat pulse:** from the previous scenario, pulse `head_valid` with head=(0,1).
  - `increment` is high for exactly one cycle. `food_valid` falls at the same edge.
  - The new food is placed on the following edge.
  - A counter driven by this pulse advances by exactly 1.
- **No false eat:** `head_valid` with head=(3,5) while food=(0,1).
  - `increment` stays 0. Food unchanged.
- **Head avoidance, macro defined:** SEED=16'h0100, head register at reset (0,0).
  - Candidates (0,0) are rejected for 3 cycles (lfsr 0100→0200→0400).
  - At the 4th edge, lfsr=0801 gives food=(0,1), `food_valid`=1.
- **Head avoidance, macro undefined:** same setup.
  - food=(0,0) and `food_valid`=1 after the first edge.
- **`enable` gating and async reset:**
  - `enable`=0 with a matching `head_valid`: no `increment`, and food/LFSR unchanged.
  - Assert `reset`=0 mid-cycle while `increment`=1: all outputs go to 0 before the next clock edge.
